// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, read FSM states and default widths
package axi_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W_DEF   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_RD,
        RS_CAP,
        RS_RESP,
        RS_ERR
    } rs_state_t;

    // WRAP bursts must span a power-of-two number of beats: 2, 4, 8 or 16.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/read_addr_gen.sv
// rtl/read_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
//
// Ports:
//   addr      current beat byte address
//   size      log2(bytes per beat)
//   len       beats minus one
//   burst     burst type encoding
//   next_addr byte address of the following beat
module read_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    import axi_pkg::*;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] size_b;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr;

    always_comb begin
        size_b    = ONE << size;
        // span = (len+1) * size; only meaningful for legal WRAP requests,
        // where it is a power of two and addr is size-aligned.
        span      = {{(ADDR_W-5){1'b0}}, ({1'b0, len} + 5'd1)} << size;
        wrap_mask = span - ONE;
        incr      = addr + size_b;
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/read_slave.sv
// rtl/read_slave.sv - AXI3 read-channel responder over a 1-cycle synchronous memory
//
// Ports:
//   ACLK, ARESET                  clock, synchronous active-high reset
//   AR* / ARVALID / ARREADY       read request channel (one outstanding)
//   RID/RDATA/RRESP/RLAST/RVALID  read data channel, RREADY backpressure
//   mem_rd_en/mem_addr/mem_rdata  word-aligned memory read port, data next cycle
module read_slave #(
    parameter int ADDR_W = axi_pkg::ADDR_W_DEF,
    parameter int DATA_W = axi_pkg::DATA_W_DEF,
    parameter int ID_W   = axi_pkg::ID_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic [1:0]        ARLOCK,
    input  logic [3:0]        ARCACHE,
    input  logic [2:0]        ARPROT,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);
    import axi_pkg::*;

    localparam int LANE_BITS = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LANE_MASK = {{(ADDR_W-LANE_BITS){1'b0}}, {LANE_BITS{1'b1}}};

    rs_state_t         state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] size_mask;
    logic              illegal;
    logic              unused_sideband;

    assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

    // Gated by ARESET so the channel is closed for the whole reset pulse.
    assign ARREADY = (state == RS_IDLE) && !ARESET;

    read_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        size_mask = (ONE << ARSIZE) - ONE;
        illegal   = 1'b0;
        if (ARBURST == BURST_RSVD) begin
            illegal = 1'b1;
        end
        if (ARSIZE > 3'(LANE_BITS)) begin
            illegal = 1'b1;
        end
        if (ARBURST == BURST_WRAP) begin
            if (!wrap_len_ok(ARLEN) || ((ARADDR & size_mask) != '0)) begin
                illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= RS_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RDATA     <= '0;
            RID       <= '0;
            RRESP     <= RESP_OKAY;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (ARVALID) begin
                        addr_q  <= ARADDR;
                        len_q   <= ARLEN;
                        size_q  <= ARSIZE;
                        burst_q <= ARBURST;
                        beat_q  <= '0;
                        RID     <= ARID;
                        if (illegal) begin
                            // Error beats need no memory: first beat is valid next cycle.
                            state  <= RS_ERR;
                            RVALID <= 1'b1;
                            RDATA  <= '0;
                            RRESP  <= RESP_SLVERR;
                            RLAST  <= (ARLEN == 4'd0);
                        end else begin
                            state     <= RS_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= ARADDR & ~LANE_MASK;
                        end
                    end
                end
                RS_RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= RS_CAP;
                end
                RS_CAP: begin
                    RDATA  <= mem_rdata;
                    RRESP  <= RESP_OKAY;
                    RLAST  <= (beat_q == len_q);
                    RVALID <= 1'b1;
                    state  <= RS_RESP;
                end
                RS_RESP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        if (beat_q == len_q) begin
                            state <= RS_IDLE;
                        end else begin
                            addr_q    <= next_addr;
                            beat_q    <= beat_q + 4'd1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= next_addr & ~LANE_MASK;
                            state     <= RS_RD;
                        end
                    end
                end
                RS_ERR: begin
                    if (RREADY) begin
                        if (beat_q == len_q) begin
                            RVALID <= 1'b0;
                            RLAST  <= 1'b0;
                            state  <= RS_IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                            RLAST  <= ((beat_q + 4'd1) == len_q);
                        end
                    end
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_slave.sv
// tb/tb_read_slave.sv - randomized self-checking bench for read_slave
module tb_read_slave;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [1:0]  ARLOCK = '0;
    logic [3:0]  ARCACHE = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;

    read_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int rr_mode = 0;

    // model state
    bit          chk_on = 0;
    bit          busy = 0;
    bit          cur_ok = 0;
    bit          want_first = 0;
    bit          prev_hold = 0;
    int          rv_due = -1;
    int          rd_due = -1;
    int          hs_cyc = 0;
    int          first_rv_cyc = 0;
    logic [31:0] prev_rdata;
    logic [3:0]  prev_rid;
    logic [1:0]  prev_rresp;
    logic        prev_rlast;
    beat_t       exp_beats[$];
    beat_t       seen_beats[$];
    logic [31:0] exp_rd[$];
    logic [31:0] seen_rd[$];

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) if (mem_rd_en) mem_rdata <= memfn(mem_addr);

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int sz,
                                              input int len, input int bu, input int i);
        longint unsigned ua, size, span, base, off;
        ua   = 64'(a);
        size = 64'd1 << sz;
        span = 64'(len + 1) * size;
        case (bu)
            1: return 32'(ua + 64'(i) * size);
            2: begin
                base = ua - (ua % span);
                off  = (ua - base + 64'(i) * size) % span;
                return 32'(base + off);
            end
            default: return a;
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] a, input int sz, input int len, input int bu);
        if (bu == 3) return 0;
        if (sz > 2) return 0;
        if (bu == 2) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 0;
            if ((64'(a) % (64'd1 << sz)) != 0) return 0;
        end
        return 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RREADY patterns: held high, toggling, random.
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (rr_mode)
                0:       RREADY = 1'b1;
                1:       RREADY = !RREADY;
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle comparison against the transaction-level model.
    initial begin
        forever begin
            bit    rv_exp, rd_exp, ar_free;
            beat_t b;
            int    ln, sz, bu;
            bit    ok;
            logic [31:0] w;
            @(negedge ACLK);
            if (chk_on) begin
                rv_exp  = (rv_due >= 0) && (cyc >= rv_due);
                rd_exp  = (rd_due >= 0) && (cyc == rd_due);
                ar_free = !busy;
                chk("arready", ARREADY, ar_free && !ARESET);
                chk("rvalid", RVALID, rv_exp);
                chk("mem_rd_en", mem_rd_en, rd_exp);
                if (mem_rd_en) seen_rd.push_back(mem_addr);
                if (rd_exp && exp_rd.size() > 0) begin
                    chk("mem_addr", mem_addr, exp_rd[0]);
                    void'(exp_rd.pop_front());
                end
                if (prev_hold && RVALID) begin
                    chk("rdata_stable", RDATA, prev_rdata);
                    chk("rid_stable", RID, prev_rid);
                    chk("rresp_stable", RRESP, prev_rresp);
                    chk("rlast_stable", RLAST, prev_rlast);
                end
                if (rv_exp && RVALID && exp_beats.size() > 0) begin
                    chk("rid", RID, exp_beats[0].id);
                    chk("rresp", RRESP, exp_beats[0].resp);
                    chk("rdata", RDATA, exp_beats[0].data);
                    chk("rlast", RLAST, exp_beats[0].last);
                end
                if (want_first && RVALID) begin
                    first_rv_cyc = cyc;
                    want_first   = 0;
                end
                if (!ARESET) begin
                    if (rv_exp && RREADY && exp_beats.size() > 0) begin
                        b.id = RID; b.resp = RRESP; b.data = RDATA; b.last = RLAST;
                        seen_beats.push_back(b);
                        void'(exp_beats.pop_front());
                        if (exp_beats.size() == 0) begin
                            busy = 0; rv_due = -1; rd_due = -1;
                        end else if (cur_ok) begin
                            rd_due = cyc + 1; rv_due = cyc + 3;
                        end else begin
                            rv_due = cyc + 1;
                        end
                    end
                    if (ARVALID && ar_free) begin
                        ln = int'(ARLEN); sz = int'(ARSIZE); bu = int'(ARBURST);
                        ok = legal(ARADDR, sz, ln, bu);
                        for (int i = 0; i <= ln; i++) begin
                            b.id   = ARID;
                            b.last = (i == ln);
                            if (ok) begin
                                w = beat_addr(ARADDR, sz, ln, bu, i) & ~32'h3;
                                exp_rd.push_back(w);
                                b.resp = 2'b00;
                                b.data = memfn(w);
                            end else begin
                                b.resp = 2'b10;
                                b.data = '0;
                            end
                            exp_beats.push_back(b);
                        end
                        busy = 1; cur_ok = ok; hs_cyc = cyc; want_first = 1;
                        if (ok) begin
                            rd_due = cyc + 1; rv_due = cyc + 3;
                        end else begin
                            rd_due = -1; rv_due = cyc + 1;
                        end
                    end
                    prev_hold  = RVALID && !RREADY;
                    prev_rdata = RDATA; prev_rid = RID; prev_rresp = RRESP; prev_rlast = RLAST;
                end else begin
                    busy = 0; rv_due = -1; rd_due = -1; want_first = 0; prev_hold = 0;
                    exp_beats.delete();
                    exp_rd.delete();
                end
            end
        end
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int sz, input int bu);
        bit got;
        @(posedge ACLK);
        #1;
        ARID = id; ARADDR = a; ARLEN = 4'(len); ARSIZE = 3'(sz); ARBURST = 2'(bu);
        ARLOCK = 2'($urandom_range(0, 3)); ARCACHE = 4'($urandom_range(0, 15));
        ARPROT = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge ACLK);
            if (ARREADY && !ARESET) got = 1;
        end
        chk("ar_accept", got, 1);
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 3000) begin
            @(negedge ACLK);
            k++;
        end
        chk("burst_done", busy, 0);
    endtask

    task automatic clear_seen();
        seen_rd.delete();
        seen_beats.delete();
    endtask

    initial begin
        logic [31:0] e_incr [4];
        logic [31:0] e_wrap [4];
        int bu, sz, ln;
        logic [31:0] ad;

        e_incr = '{32'h100, 32'h104, 32'h108, 32'h10C};
        e_wrap = '{32'h38, 32'h3C, 32'h30, 32'h34};

        // pin the model's burst arithmetic against hand-computed values
        for (int i = 0; i < 4; i++) begin
            chk("model_wrap", beat_addr(32'h38, 2, 3, 2, i), e_wrap[i]);
            chk("model_incr", beat_addr(32'h100, 2, 3, 1, i), e_incr[i]);
        end
        chk("model_incr_rollover", beat_addr(32'hFFFF_FFFC, 2, 1, 1, 1), 32'h0);
        chk("model_wrap_len2_illegal", legal(32'h0, 2, 2, 2), 0);
        chk("model_rsvd_illegal", legal(32'h0, 2, 1, 3), 0);

        // reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk_on = 1;
        @(negedge ACLK);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rid", RID, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("arready_after_release", ARREADY, 1);

        // INCR 0x100, len 3
        clear_seen();
        send_ar(4'h3, 32'h100, 3, 2, 1);
        wait_idle();
        chk("incr_reads", seen_rd.size(), 4);
        for (int i = 0; i < 4 && i < seen_rd.size(); i++) chk("incr_addr", seen_rd[i], e_incr[i]);
        chk("incr_beats", seen_beats.size(), 4);
        for (int i = 0; i < seen_beats.size(); i++) begin
            chk("incr_rlast", seen_beats[i].last, (i == 3));
            chk("incr_okay", seen_beats[i].resp, 2'b00);
        end
        chk("incr_latency", first_rv_cyc - hs_cyc, 3);

        // WRAP 0x38, len 3
        clear_seen();
        send_ar(4'h1, 32'h38, 3, 2, 2);
        wait_idle();
        chk("wrap_reads", seen_rd.size(), 4);
        for (int i = 0; i < 4 && i < seen_rd.size(); i++) chk("wrap_addr", seen_rd[i], e_wrap[i]);

        // FIXED 0x20, len 2 with toggling RREADY
        rr_mode = 1;
        clear_seen();
        send_ar(4'h2, 32'h20, 2, 2, 0);
        wait_idle();
        chk("fixed_reads", seen_rd.size(), 3);
        for (int i = 0; i < seen_rd.size(); i++) chk("fixed_addr", seen_rd[i], 32'h20);
        chk("fixed_beats", seen_beats.size(), 3);
        rr_mode = 0;

        // reserved burst -> SLVERR
        clear_seen();
        send_ar(4'h5, 32'h80, 1, 2, 3);
        wait_idle();
        chk("rsvd_reads", seen_rd.size(), 0);
        chk("rsvd_beats", seen_beats.size(), 2);
        for (int i = 0; i < seen_beats.size(); i++) begin
            chk("rsvd_resp", seen_beats[i].resp, 2'b10);
            chk("rsvd_data", seen_beats[i].data, 0);
            chk("rsvd_id", seen_beats[i].id, 4'h5);
            chk("rsvd_last", seen_beats[i].last, (i == 1));
        end
        chk("err_latency", first_rv_cyc - hs_cyc, 1);

        // reset during beat 2 of an INCR len 7 burst
        clear_seen();
        send_ar(4'h7, 32'h200, 7, 2, 1);
        for (int k = 0; k < 100 && seen_beats.size() < 2; k++) @(negedge ACLK);
        chk("pre_reset_beats", seen_beats.size(), 2);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rlast", RLAST, 0);
        chk("mid_rst_rdata", RDATA, 0);
        chk("mid_rst_rid", RID, 0);
        chk("mid_rst_rresp", RRESP, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_arready", ARREADY, 1);
        repeat (5) @(negedge ACLK);
        clear_seen();
        send_ar(4'h9, 32'h40, 0, 2, 1);
        wait_idle();
        chk("post_rst_beats", seen_beats.size(), 1);
        if (seen_beats.size() > 0) begin
            chk("post_rst_resp", seen_beats[0].resp, 2'b00);
            chk("post_rst_data", seen_beats[0].data, memfn(32'h40));
            chk("post_rst_last", seen_beats[0].last, 1);
        end

        // WRAP with len 2 is illegal
        clear_seen();
        send_ar(4'h4, 32'h10, 2, 2, 2);
        wait_idle();
        chk("wrap3_beats", seen_beats.size(), 3);
        for (int i = 0; i < seen_beats.size(); i++) chk("wrap3_resp", seen_beats[i].resp, 2'b10);
        chk("wrap3_reads", seen_rd.size(), 0);

        // randomized requests with random backpressure
        rr_mode = 2;
        for (int n = 0; n < 60; n++) begin
            bu = int'($urandom_range(0, 3));
            sz = int'($urandom_range(0, 3));
            ln = int'($urandom_range(0, 15));
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad = ad & ~32'h7F;
            if ($urandom_range(0, 7) == 0) ad = 32'hFFFF_FFF0;
            repeat ($urandom_range(0, 3)) @(posedge ACLK);
            send_ar(4'($urandom_range(0, 15)), ad, ln, sz, bu);
            wait_idle();
        end
        rr_mode = 0;
        repeat (4) @(negedge ACLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/read_slave.md
# read_slave

AXI3 read-channel responder: the read-direction counterpart to the write slave, sitting between the interconnect and the local memory. It accepts one AR request at a time and issues single-word reads to a synchronous memory port with 1-cycle latency. It returns ARLEN+1 R beats with RID, RRESP and RLAST, honouring RREADY backpressure. Together with the write slave it forms the complete slave side of the test fabric.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; legal values 32 or 64
- ID_W, 4, transaction ID width

Ports:
- ACLK  in  1  sole clock, rising edge
- ARESET  in  1  synchronous, active-high reset
- ARID  in  ID_W  read request ID
- ARADDR  in  ADDR_W  start byte address
- ARLEN  in  4  beats minus one
- ARSIZE  in  3  bytes per beat = 1<<ARSIZE
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ARLOCK  in  2  accepted and ignored; no exclusive monitor
- ARCACHE  in  4  ignored
- ARPROT  in  3  ignored
- ARVALID  in  1  request valid
- ARREADY  out  1  request accept
- RID  out  ID_W  echoes latched ARID
- RDATA  out  DATA_W  read data
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat
- RVALID  out  1  beat valid
- RREADY  in  1  master accepts beat
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  beat address, low log2(DATA_W/8) bits zero
- mem_rdata  in  DATA_W  valid the cycle after mem_rd_en

## Operation
- FSM states: IDLE, RD, CAP, RESP, ERR.
- IDLE:
  - ARREADY=1.
  - On ARVALID&&ARREADY, latch ID, address, LEN, SIZE and BURST; clear the beat counter.
  - Go to ERR if the request is illegal, else to RD.
- A request is illegal (SLVERR) when any of these holds:
  - ARBURST=11.
  - ARSIZE > log2(DATA_W/8).
  - WRAP with ARLEN not in {1,3,7,15}.
  - WRAP with ARADDR not aligned to 1<<ARSIZE.
- RD: mem_rd_en=1 and mem_addr=beat address for one cycle. Go to CAP.
- CAP: register mem_rdata into the RDATA holding register. Go to RESP.
- RESP:
  - RVALID=1, RRESP=00, RLAST=(beat==ARLEN).
  - RDATA/RID/RRESP/RLAST stay stable until the handshake.
  - On RVALID&&RREADY: if last, go to IDLE; else advance the address, increment the beat counter, go to RD.
- ERR:
  - RVALID=1, RDATA=0, RRESP=10, RLAST=(beat==ARLEN).
  - No memory access.
  - Advance on each handshake; go to IDLE after the last beat.
- Address generation, with size = 1<<ARSIZE:
  - FIXED: address unchanged.
  - INCR: addr+size, ADDR_W-bit wraparound; 4 KB crossings are not checked.
  - WRAP: span=(ARLEN+1)*size; next = (addr & ~(span-1)) | ((addr+size) & (span-1)).
- Narrow transfers return the full memory word; the master selects byte lanes.

## Timing
- Reset:
  - ARESET sampled high forces IDLE and clears the beat counter.
  - Registered outputs reset to 0: RVALID, RLAST, RDATA, RID, RRESP, mem_rd_en, mem_addr.
  - ARREADY is 0 while ARESET is high and 1 the first cycle after release.
- Reset mid-burst abandons the transaction. No further beats are sent and no memory read is issued afterwards.
- AR handshake at edge T: RD during T+1, CAP during T+2, first RVALID at T+3.
- OKAY throughput is one beat per 3 cycles with RREADY held high.
- ERR throughput is one beat per cycle with RREADY held high. The first error beat is valid the cycle after the AR handshake.
- ARREADY falls the cycle after the AR handshake and returns the cycle after the final R handshake. Only one outstanding request is allowed.
- RVALID never depends combinationally on RREADY. Once raised, RVALID is not dropped before the handshake.
- RREADY low in RESP holds state indefinitely, with no additional memory reads.

## Structure
- Shared package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the FSM state enum;
  - default width constants.
- Sub-module read_addr_gen: purely combinational next-address logic from (addr, size, len, burst). The write slave reuses it.

## Test plan
- INCR, ARADDR=0x100, ARLEN=3, ARSIZE=2, RREADY=1 -> mem_addr 0x100, 0x104, 0x108, 0x10C; 4 OKAY beats; RLAST on beat 3 only; first RVALID 3 cycles after the AR handshake.
- WRAP, ARADDR=0x38, ARLEN=3, ARSIZE=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34.
- FIXED, ARADDR=0x20, ARLEN=2 with RREADY toggling 0,1 -> three reads at 0x20; RDATA stable while RVALID&&!RREADY; one mem_rd_en per beat.
- ARBURST=11, ARLEN=1, ARID=5 -> 2 beats, RRESP=10, RDATA=0, RID=5, RLAST on beat 1; mem_rd_en never asserted.
- ARESET pulsed during beat 2 of an ARLEN=7 INCR burst -> all outputs 0 next cycle, ARREADY=1 after release; a new ARLEN=0 request completes with OKAY.
- WRAP with ARLEN=2 -> 3 SLVERR beats.
